shift_ctrl: RTL and testbench



---
 rtl/shift_ctrl_pkg.sv | 17 +
 rtl/shift_ctrl_if.sv | 36 +++
 rtl/shift_ctrl_cnt.sv | 25 ++
 rtl/shift_ctrl.sv | 149 ++++++++++++++
 tb/tb_shift_ctrl.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/shift_ctrl_pkg.sv
// shift_ctrl shared types: FSM state encoding and parameter limits.
// Imported by the controller, its counter and the verification bench.
package shift_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;
    localparam int GAP_MIN   = 0;
    localparam int GAP_MAX   = 15;
    localparam int GAP_CW    = 4;

endpackage

// File: rtl/shift_ctrl_if.sv
// shift_ctrl bus: word handshake in, serial bit handshake out, status.
// slave = controller view, master = producer/consumer view.
interface shift_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             sout;
    logic             sout_valid;
    logic             sout_ready;
    logic             busy;
    logic             frame_done;

    modport slave (
        input  in_valid,
        input  in_data,
        input  sout_ready,
        output in_ready,
        output sout,
        output sout_valid,
        output busy,
        output frame_done
    );

    modport master (
        output in_valid,
        output in_data,
        output sout_ready,
        input  in_ready,
        input  sout,
        input  sout_valid,
        input  busy,
        input  frame_done
    );
endinterface

// File: rtl/shift_ctrl_cnt.sv
// Loadable up/down counter, load has priority over count enable.
// Ports: clk, rst_n (async clear), load/load_val, en, up, cnt.
module shift_ctrl_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic         up,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en) begin
            cnt <= up ? cnt + W'(1) : cnt - W'(1);
        end
    end

endmodule

// File: rtl/shift_ctrl.sv
// Parallel-to-serial sequencer: word in, LSB-first bits out, idle gap.
// Ports: clk, rst (async, active-low), bus (shift_ctrl_if.slave).
module shift_ctrl
    import shift_ctrl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int GAP   = 1
) (
    input  logic        clk,
    input  logic        rst,
    shift_ctrl_if.slave bus
);

    localparam int BW = $clog2(WIDTH);

    generate
        if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
            $error("shift_ctrl: WIDTH out of range");
        end
        if (GAP < GAP_MIN || GAP > GAP_MAX) begin : g_bad_gap
            $error("shift_ctrl: GAP out of range");
        end
    endgenerate

    state_t state;
    state_t state_nx;

    logic [WIDTH-1:0]  word;
    logic [BW-1:0]     bitcnt;
    logic [GAP_CW-1:0] gapcnt;

    logic accept;
    logic consume;
    logic last;
    logic fire_last;
    logic frame_done_q;

    logic in_ready_c;
    logic busy_c;
    logic sout_valid_c;
    logic sout_c;

    assign accept    = (state == ST_IDLE) && bus.in_valid;
    assign consume   = (state == ST_SHIFT) && bus.sout_ready;
    assign last      = (bitcnt == BW'(WIDTH - 1));
    assign fire_last = consume && last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nx = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (fire_last) begin
                    state_nx = (GAP == 0) ? ST_IDLE : ST_GAP;
                end
            end
            ST_GAP: begin
                if (gapcnt == GAP_CW'(1)) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready_c   = 1'b0;
        busy_c       = 1'b0;
        sout_valid_c = 1'b0;
        sout_c       = 1'b0;
        unique case (state)
            ST_IDLE: begin
                in_ready_c = 1'b1;
            end
            ST_SHIFT: begin
                busy_c       = 1'b1;
                sout_valid_c = 1'b1;
                sout_c       = word[bitcnt];
            end
            ST_GAP: begin
                busy_c = 1'b1;
            end
            default: begin
                in_ready_c = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word <= '0;
        end else if (accept) begin
            word <= bus.in_data;
        end
    end

    // Pulse lands in the cycle after the last bit is taken.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= fire_last;
        end
    end

    // Reload to zero after the last bit so the count never wraps.
    shift_ctrl_cnt #(
        .W(BW)
    ) u_bitcnt (
        .clk      (clk),
        .rst_n    (rst),
        .load     (accept || fire_last),
        .load_val ('0),
        .en       (consume),
        .up       (1'b1),
        .cnt      (bitcnt)
    );

    shift_ctrl_cnt #(
        .W(GAP_CW)
    ) u_gapcnt (
        .clk      (clk),
        .rst_n    (rst),
        .load     (fire_last),
        .load_val (GAP_CW'(GAP)),
        .en       (state == ST_GAP),
        .up       (1'b0),
        .cnt      (gapcnt)
    );

    assign bus.in_ready   = in_ready_c;
    assign bus.busy       = busy_c;
    assign bus.sout_valid = sout_valid_c;
    assign bus.sout       = sout_c;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_shift_ctrl.sv
// Directed bench for shift_ctrl: GAP=1 instance and a GAP=0 instance.
// Status vector is {in_ready, busy, sout_valid, sout, frame_done}.
module tb_shift_ctrl;
    import shift_ctrl_pkg::*;

    logic clk;
    logic rst;
    int   passed;
    int   total;

    shift_ctrl_if #(.WIDTH(4)) bus0 ();
    shift_ctrl_if #(.WIDTH(4)) bus1 ();

    shift_ctrl #(.WIDTH(4), .GAP(1)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    shift_ctrl #(.WIDTH(4), .GAP(0)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [4:0] V_IDLE = 5'b10000;
    localparam logic [4:0] V_B1   = 5'b01110;
    localparam logic [4:0] V_B0   = 5'b01100;
    localparam logic [4:0] V_GAPD = 5'b01001;
    localparam logic [4:0] V_IDLD = 5'b10001;

    function automatic logic [4:0] v0();
        return {bus0.in_ready, bus0.busy, bus0.sout_valid,
                bus0.sout, bus0.frame_done};
    endfunction

    function automatic logic [4:0] v1();
        return {bus1.in_ready, bus1.busy, bus1.sout_valid,
                bus1.sout, bus1.frame_done};
    endfunction

    task automatic chk(input string tag, input logic [4:0] obs,
                       input logic [4:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst = 1'b0;
        bus0.in_valid   = 1'b0;
        bus0.in_data    = 4'h0;
        bus0.sout_ready = 1'b1;
        bus1.in_valid   = 1'b0;
        bus1.in_data    = 4'h0;
        bus1.sout_ready = 1'b1;

        #3;
        chk("rst0", v0(), V_IDLE);
        chk("rst1", v1(), V_IDLE);
        step();
        step();
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("idle0_%0d", i), v0(), V_IDLE);
            chk($sformatf("idle1_%0d", i), v1(), V_IDLE);
        end

        // Plain frame 1011, no stalls.
        bus0.in_data  = 4'b1011;
        bus0.in_valid = 1'b1;
        step();
        bus0.in_valid = 1'b0;
        chk("f1_b0", v0(), V_B1);
        step();
        chk("f1_b1", v0(), V_B1);
        step();
        chk("f1_b2", v0(), V_B0);
        step();
        chk("f1_b3", v0(), V_B1);
        step();
        chk("f1_done", v0(), V_GAPD);
        step();
        chk("f1_rdy", v0(), V_IDLE);
        step();
        chk("f1_idle", v0(), V_IDLE);

        // Same word, bit 1 stalled for three cycles.
        bus0.in_valid = 1'b1;
        step();
        bus0.in_valid = 1'b0;
        chk("st_b0", v0(), V_B1);
        step();
        chk("st_b1a", v0(), V_B1);
        bus0.sout_ready = 1'b0;
        step();
        chk("st_b1b", v0(), V_B1);
        step();
        chk("st_b1c", v0(), V_B1);
        step();
        chk("st_b1d", v0(), V_B1);
        bus0.sout_ready = 1'b1;
        step();
        chk("st_b2", v0(), V_B0);
        step();
        chk("st_b3", v0(), V_B1);
        step();
        chk("st_done", v0(), V_GAPD);
        step();
        chk("st_rdy", v0(), V_IDLE);

        // in_valid held through SHIFT and GAP with a different word.
        bus0.in_data  = 4'b1011;
        bus0.in_valid = 1'b1;
        step();
        bus0.in_data = 4'b0100;
        chk("bz_b0", v0(), V_B1);
        step();
        chk("bz_b1", v0(), V_B1);
        step();
        chk("bz_b2", v0(), V_B0);
        step();
        chk("bz_b3", v0(), V_B1);
        step();
        chk("bz_gap", v0(), V_GAPD);
        step();
        chk("bz_rdy", v0(), V_IDLE);
        step();
        bus0.in_valid = 1'b0;
        chk("bz2_b0", v0(), V_B0);
        step();
        chk("bz2_b1", v0(), V_B0);
        step();
        chk("bz2_b2", v0(), V_B1);
        step();
        chk("bz2_b3", v0(), V_B0);
        step();
        chk("bz2_done", v0(), V_GAPD);
        step();
        chk("bz2_rdy", v0(), V_IDLE);

        // Reset in the middle of a frame, then 4'hF.
        bus0.in_data  = 4'b1011;
        bus0.in_valid = 1'b1;
        step();
        bus0.in_valid = 1'b0;
        step();
        step();
        chk("rm_b2", v0(), V_B0);
        rst = 1'b0;
        bus0.in_data  = 4'hF;
        bus0.in_valid = 1'b1;
        #1;
        chk("rm_async", v0(), V_IDLE);
        step();
        chk("rm_hold", v0(), V_IDLE);
        step();
        chk("rm_nodone", v0(), V_IDLE);
        rst = 1'b1;
        step();
        bus0.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rm_f_b%0d", i), v0(), V_B1);
            step();
        end
        chk("rm_done", v0(), V_GAPD);
        step();
        chk("rm_rdy", v0(), V_IDLE);

        // GAP=0 instance: A then 5 back to back.
        bus1.in_data  = 4'hA;
        bus1.in_valid = 1'b1;
        step();
        bus1.in_data = 4'h5;
        chk("bb_a0", v1(), V_B0);
        step();
        chk("bb_a1", v1(), V_B1);
        step();
        chk("bb_a2", v1(), V_B0);
        step();
        chk("bb_a3", v1(), V_B1);
        step();
        chk("bb_adone", v1(), V_IDLD);
        step();
        bus1.in_valid = 1'b0;
        chk("bb_50", v1(), V_B1);
        step();
        chk("bb_51", v1(), V_B0);
        step();
        chk("bb_52", v1(), V_B1);
        step();
        chk("bb_53", v1(), V_B0);
        step();
        chk("bb_5done", v1(), V_IDLD);
        step();
        chk("bb_idle", v1(), V_IDLE);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
